// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction-memory loader: framed UART bytes to word-aligned
// RAM writes, with checksum-gated CPU release and an ACK/NAK reply per frame.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);
  localparam logic [7:0]      SYNC    = 8'hA5;
  localparam logic [7:0]      ACK     = 8'h06;
  localparam logic [7:0]      NAK     = 8'h15;
  localparam logic [16:0]     MAX_N   = 17'(2 ** ADDR_W);
  localparam logic [31:0]     TMO     = 32'(TIMEOUT);
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK, S_RESP, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [7:0]      cnt_hi, cnt_hi_n;
  logic [ADDR_W:0] cnt, cnt_n, idx, idx_n;
  logic [1:0]      lane, lane_n;
  logic [23:0]     shift, shift_n;
  logic [7:0]      csum, csum_n;
  logic [31:0]     tmr, tmr_n;
  logic [7:0]      tx_data_q, tx_data_n;
  logic            wr_en_q, wr_en_n;
  logic [31:0]     wr_addr_q, wr_addr_n, wr_data_q, wr_data_n;
  logic            hold_q, hold_n, done_q, done_n, err_q, err_n;
  logic            fire, in_frame;
  logic [15:0]     n16;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_hi    <= '0;
      cnt       <= '0;
      idx       <= '0;
      lane      <= '0;
      shift     <= '0;
      csum      <= '0;
      tmr       <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_hi    <= cnt_hi_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      lane      <= lane_n;
      shift     <= shift_n;
      csum      <= csum_n;
      tmr       <= tmr_n;
      tx_data_q <= tx_data_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      hold_q    <= hold_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_hi_n  = cnt_hi;
    cnt_n     = cnt;
    idx_n     = idx;
    lane_n    = lane;
    shift_n   = shift;
    csum_n    = csum;
    tmr_n     = tmr;
    tx_data_n = tx_data_q;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    hold_n    = hold_q;
    done_n    = done_q;
    err_n     = err_q;
    fire      = 1'b0;
    n16       = {cnt_hi, rx_data};
    in_frame  = (state == S_CNT_HI) || (state == S_CNT_LO) ||
                (state == S_DATA)   || (state == S_CHECK);

    if (in_frame) tmr_n = rx_valid ? 32'd0 : tmr + 32'd1;

    // An expiring timer takes priority over a byte arriving in the same cycle.
    if (in_frame && tmr == TMO) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (rx_valid && rx_data == SYNC) begin
            state_n = S_CNT_HI;
            hold_n  = 1'b1;
            done_n  = 1'b0;
            err_n   = 1'b0;
            csum_n  = '0;
            idx_n   = '0;
            lane_n  = '0;
            tmr_n   = '0;
          end
        end
        S_CNT_HI: begin
          if (rx_valid) begin
            cnt_hi_n = rx_data;
            state_n  = S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (rx_valid) begin
            if (n16 == 16'd0 || {1'b0, n16} > MAX_N) begin
              tx_data_n = NAK;
              state_n   = S_RESP;
            end else begin
              cnt_n   = n16[ADDR_W:0];
              state_n = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            csum_n  = csum + rx_data;
            shift_n = {shift[15:0], rx_data};
            lane_n  = lane + 2'd1;
            if (lane == 2'd3) begin
              wr_en_n   = 1'b1;
              wr_addr_n = 32'({idx[ADDR_W-1:0], 2'b00});
              wr_data_n = {shift, rx_data};
              idx_n     = idx + IDX_ONE;
              if (idx + IDX_ONE == cnt) state_n = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (rx_valid) begin
            tx_data_n = (rx_data == csum) ? ACK : NAK;
            state_n   = S_RESP;
          end
        end
        S_RESP: begin
          if (!tx_busy) begin
            fire = 1'b1;
            if (tx_data_q == ACK) begin
              hold_n  = 1'b0;
              done_n  = 1'b1;
              state_n = S_DONE;
            end else begin
              err_n   = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Status flags switch in the very cycle the response byte is launched.
  assign tx_start   = fire;
  assign tx_data    = tx_data_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = fire ? hold_n : hold_q;
  assign load_done  = fire ? done_n : done_q;
  assign load_error = fire ? err_n  : err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader with a frame-level
// reference model predicting writes, responses and status flags per cycle.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int TMO    = 40;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start, wr_en;
  logic [31:0] wr_addr, wr_data;
  logic        cpu_hold, load_done, load_error;

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] b; } rsp_t;
  typedef struct { int cyc; bit hold; bit done; bit err; } flg_t;

  wr_t  wq[$];
  rsp_t rq[$];
  flg_t fq[$];
  bit   exp_hold = 1'b1, exp_done = 1'b0, exp_err = 1'b0;
  bit   chk_en = 1'b0;
  bit   busy_rand = 1'b0;
  int   busy_until = 0;
  int   errors = 0, checks = 0;
  int   n_wr = 0, n_tx = 0, last_tx_cyc = 0;
  logic [7:0]  last_tx_byte = 8'h00;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    tx_busy = (cyc < busy_until) || (busy_rand && ($urandom_range(0, 3) == 0));
  end

  // Per-cycle comparison of the DUT against the model's expected event queues.
  always @(negedge clk) begin
    if (chk_en) begin
      while (fq.size() > 0 && fq[0].cyc <= cyc) begin
        exp_hold = fq[0].hold;
        exp_done = fq[0].done;
        exp_err  = fq[0].err;
        void'(fq.pop_front());
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        check("wr_en", wr_en, 1);
        check("wr_addr", wr_addr, wq[0].addr);
        check("wr_data", wr_data, wq[0].data);
        void'(wq.pop_front());
      end else begin
        check("wr_en_idle", wr_en, 0);
      end
      if (wr_en) begin
        n_wr++;
        last_wr_addr = wr_addr;
        last_wr_data = wr_data;
      end
      if (rq.size() > 0 && cyc >= rq[0].cyc && !tx_busy) begin
        check("tx_start", tx_start, 1);
        check("tx_data", tx_data, rq[0].b);
        exp_hold = (rq[0].b != ACK);
        exp_done = (rq[0].b == ACK);
        exp_err  = (rq[0].b != ACK);
        void'(rq.pop_front());
      end else begin
        check("tx_start_idle", tx_start, 0);
      end
      if (tx_start) begin
        n_tx++;
        last_tx_cyc  = cyc;
        last_tx_byte = tx_data;
      end
      check("cpu_hold", cpu_hold, exp_hold);
      check("load_done", load_done, exp_done);
      check("load_error", load_error, exp_err);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int k);
    repeat (gap) begin @(posedge clk); #1; rx_valid = 1'b0; end
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    k = cyc;
  endtask

  task automatic release_rx();
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((wq.size() + rq.size() + fq.size()) != 0 && t < TMO + 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(wq.size() + rq.size() + fq.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Frame-level model: predicts every write, the reply byte and any timeout from the bytes sent.
  task automatic send_frame(input logic [7:0] f[$], input int gmax, input bit do_drain);
    int k = 0, n = 0, need;
    bit ok_n = 1'b0;
    logic [7:0]  s = 8'h00;
    logic [31:0] w = 32'h0;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], $urandom_range(0, gmax), k);
      if (i == 0) fq.push_back('{cyc: k + 1, hold: 1'b1, done: 1'b0, err: 1'b0});
      if (i == 2) begin
        n = {f[1], f[2]};
        ok_n = (n >= 1) && (n <= (1 << ADDR_W));
        if (!ok_n) rq.push_back('{cyc: k + 1, b: NAK});
      end
      if (ok_n && i >= 3 && i < 3 + 4 * n) begin
        s = s + f[i];
        w = {w[23:0], f[i]};
        if ((i - 3) % 4 == 3) wq.push_back('{cyc: k + 1, addr: 32'((i - 3) / 4 * 4), data: w});
      end
      if (ok_n && i == 3 + 4 * n) rq.push_back('{cyc: k + 1, b: (f[i] == s) ? ACK : NAK});
    end
    release_rx();
    need = ok_n ? 4 + 4 * n : 3;
    if (f.size() < need) fq.push_back('{cyc: k + 2 + TMO, hold: 1'b1, done: 1'b0, err: 1'b1});
    if (do_drain) drain();
  endtask

  task automatic make_frame(input int n, input bit bad, output logic [7:0] f[$]);
    logic [7:0] s = 8'h00, b;
    f = {};
    f.push_back(8'hA5);
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      s = s + b;
    end
    f.push_back(bad ? (s ^ 8'($urandom_range(1, 255))) : s);
  endtask

  task automatic send_garbage();
    int k;
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h5A;
    send_byte(b, $urandom_range(0, 3), k);
    release_rx();
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    logic [7:0] s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_error"}, load_error, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] d[$];
    int w0, t0, c0, sel, n;

    repeat (3) @(posedge clk); #1;
    check_reset_values("rst");
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    d = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    check("sum8_pin", sum8(d), 8'h38);

    f = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
    w0 = n_wr;
    send_frame(f, 0, 1);
    check("good_nwr", n_wr - w0, 2);
    check("good_last_addr", last_wr_addr, 32'h4);
    check("good_last_data", last_wr_data, 32'h9ABCDEF0);
    check("good_ack", last_tx_byte, 8'h06);
    check("good_done", load_done, 1);
    check("good_hold", cpu_hold, 0);

    f[11] = 8'hC9;
    w0 = n_wr;
    send_frame(f, 1, 1);
    check("bad_nwr", n_wr - w0, 2);
    check("bad_nak", last_tx_byte, 8'h15);
    check("bad_hold", cpu_hold, 1);
    check("bad_err", load_error, 1);
    f[11] = 8'h38;
    send_frame(f, 2, 1);
    check("regood_ack", last_tx_byte, 8'h06);

    w0 = n_wr; t0 = n_tx;
    send_frame('{8'hA5, 8'h00, 8'h00}, 0, 1);
    check("cnt0_nak", last_tx_byte, 8'h15);
    send_frame('{8'hA5, 8'h01, 8'h01}, 0, 1);
    check("cnt257_nak", last_tx_byte, 8'h15);
    check("cnt_rej_nwr", n_wr - w0, 0);
    check("cnt_rej_ntx", n_tx - t0, 2);
    make_frame(256, 1'b0, f);
    w0 = n_wr;
    send_frame(f, 0, 1);
    check("cnt256_nwr", n_wr - w0, 256);
    check("cnt256_ack", last_tx_byte, 8'h06);

    make_frame(2, 1'b0, f);
    c0 = cyc;
    busy_until = c0 + 63;
    send_frame(f, 0, 1);
    check("busy_tx_cycle", last_tx_cyc, c0 + 63);

    f = {8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(f, 0, 0);
    @(posedge clk); #2;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    wq.delete(); rq.delete(); fq.delete();
    exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    w0 = n_wr; t0 = n_tx;
    send_frame('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22}, 0, 1);
    check("tmo_err", load_error, 1);
    check("tmo_hold", cpu_hold, 1);
    check("tmo_nwr", n_wr - w0, 0);
    check("tmo_ntx", n_tx - t0, 0);
    repeat (3) send_garbage();
    check("garbage_ntx", n_tx - t0, 0);
    make_frame(1, 1'b0, f);
    send_frame(f, 1, 1);
    check("post_tmo_ack", last_tx_byte, 8'h06);

    make_frame(3, 1'b0, f);
    w0 = n_wr;
    send_frame(f, 0, 1);
    check("reload_nwr", n_wr - w0, 3);
    check("reload_done", load_done, 1);

    busy_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 9);
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) send_garbage();
      if (sel == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : 257 + $urandom_range(0, 500);
        f = {8'hA5, 8'(n >> 8), 8'(n)};
      end else begin
        make_frame(n, sel < 3, f);
        if (sel == 3) begin
          n = $urandom_range(1, f.size() - 1);
          while (f.size() > n) void'(f.pop_back());
        end
      end
      send_frame(f, 2, 1);
    end
    busy_rand = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
